// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns one-cycle request pulses into HIGH_CYCLES-wide levels.
// Each level is followed by a GAP_CYCLES low gap. Requests that arrive while a level
// or gap is in progress are counted in a saturating pending counter and replayed
// in order. A dropped request sets a sticky overflow flag.
module pulse_stretcher #(
   parameter int HIGH_CYCLES = 4,
   parameter int GAP_CYCLES  = 2,
   parameter int PEND_W      = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pulse_in,
   input  logic              clr_overflow,
   output logic              signal_out,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              overflow
);

   localparam int MAXC = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [CW-1:0]     H_LOAD = CW'(HIGH_CYCLES - 1);
   localparam logic [CW-1:0]     G_LOAD = CW'(GAP_CYCLES - 1);
   localparam logic [PEND_W-1:0] P_MAX  = {PEND_W{1'b1}};
   localparam logic [PEND_W-1:0] P_ONE  = PEND_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HIGH = 2'd1,
      S_GAP  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [PEND_W-1:0] pending_q, pending_d;
   logic              overflow_q, overflow_d;
   logic              signal_out_q, signal_out_d;
   logic              busy_q, busy_d;
   logic              queue_req;
   logic              drop;

   // Next state, down-counter, pending accounting and sticky overflow.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pending_d  = pending_q;
      overflow_d = overflow_q;
      queue_req  = 1'b0;

      case (state_q)
         S_IDLE: begin
            // A pulse here starts a level immediately and is never queued.
            if (pulse_in) begin
               state_d = S_HIGH;
               cnt_d   = H_LOAD;
            end
         end
         S_HIGH: begin
            queue_req = pulse_in;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = S_GAP;
               cnt_d   = G_LOAD;
            end
         end
         S_GAP: begin
            if (cnt_q != '0) begin
               cnt_d     = cnt_q - 1'b1;
               queue_req = pulse_in;
            end else if (pending_q != '0 || pulse_in) begin
               // Serve: oldest queued request first; a new pulse replaces it in
               // the queue (net zero), or is served directly when the queue is empty.
               state_d = S_HIGH;
               cnt_d   = H_LOAD;
               if (pending_q != '0 && !pulse_in) pending_d = pending_q - P_ONE;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      drop = queue_req && (pending_q == P_MAX);
      if (queue_req && !drop) pending_d = pending_q + P_ONE;

      // Setting wins over clearing in the same cycle.
      if (drop)              overflow_d = 1'b1;
      else if (clr_overflow) overflow_d = 1'b0;

      signal_out_d = (state_d == S_HIGH);
      busy_d       = (state_d != S_IDLE);
   end

   // State register; outputs come straight from flops so they cannot glitch.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         pending_q    <= '0;
         overflow_q   <= 1'b0;
         signal_out_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pending_q    <= pending_d;
         overflow_q   <= overflow_d;
         signal_out_q <= signal_out_d;
         busy_q       <= busy_d;
      end
   end

   assign signal_out = signal_out_q;
   assign busy       = busy_q;
   assign pending    = pending_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher. Two instances share stimulus: a default one
// (PEND_W=3) and a shallow one (PEND_W=2) for saturation/overflow.
// Loop index t = edge number; outputs seen after edge t are "cycle t+1".
module tb_pulse_stretcher;

   logic       clk = 1'b0;
   logic       reset, pulse_in, clr_overflow;
   logic       out_a, busy_a, ovf_a;
   logic [1:0] pend_a;
   logic       out_b, busy_b, ovf_b;
   logic [2:0] pend_b;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pulse_stretcher #(.HIGH_CYCLES(4), .GAP_CYCLES(2), .PEND_W(2)) u_a (
      .clk(clk), .reset(reset), .pulse_in(pulse_in), .clr_overflow(clr_overflow),
      .signal_out(out_a), .busy(busy_a), .pending(pend_a), .overflow(ovf_a)
   );

   pulse_stretcher u_b (
      .clk(clk), .reset(reset), .pulse_in(pulse_in), .clr_overflow(clr_overflow),
      .signal_out(out_b), .busy(busy_b), .pending(pend_b), .overflow(ovf_b)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit rng(input int c, input int lo, input int hi);
      return (c >= lo) && (c <= hi);
   endfunction

   function automatic bit drv_pulse(input int s, input int t);
      case (s)
         1: return t == 10;
         2: return t == 10 || t == 12 || t == 13;
         3: return t == 10 || t == 16;
         4: return t == 10 || rng(t, 12, 15) || rng(t, 21, 23);
         5: return rng(t, 10, 12) || t == 14;
         6: return rng(t, 10, 12);
         default: return 1'b0;
      endcase
   endfunction

   function automatic int exp_out(input int s, input int c);
      case (s)
         1: return rng(c, 11, 14);
         3: return rng(c, 11, 14) || rng(c, 17, 20);
         5: return rng(c, 11, 12) || rng(c, 15, 18);
         default: return rng(c, 11, 14) || rng(c, 17, 20) || rng(c, 23, 26);
      endcase
   endfunction

   function automatic int exp_busy(input int s, input int c);
      case (s)
         1: return rng(c, 11, 16);
         3: return rng(c, 11, 22);
         4: return rng(c, 11, 24);
         5: return rng(c, 11, 12) || rng(c, 15, 20);
         default: return rng(c, 11, 28);
      endcase
   endfunction

   // Pending count of the shallow instance (identical to the deep one except in 4).
   function automatic int exp_pend_a(input int s, input int c);
      case (s)
         2: return c == 13 ? 1 : rng(c, 14, 16) ? 2 : rng(c, 17, 22) ? 1 : 0;
         6: return c == 12 ? 1 : rng(c, 13, 16) ? 2 : rng(c, 17, 22) ? 1 : 0;
         4: return c == 13 ? 1 : c == 14 ? 2 : rng(c, 15, 16) ? 3 :
                   rng(c, 17, 21) ? 2 : rng(c, 22, 24) ? 3 : 0;
         5: return c == 12 ? 1 : 0;
         default: return 0;
      endcase
   endfunction

   function automatic int exp_pend_b(input int s, input int c);
      if (s != 4) return exp_pend_a(s, c);
      return c == 13 ? 1 : c == 14 ? 2 : c == 15 ? 3 : c == 16 ? 4 :
             rng(c, 17, 21) ? 3 : rng(c, 22, 23) ? 4 : c == 24 ? 5 : 0;
   endfunction

   function automatic int exp_ovf_a(input int s, input int c);
      if (s != 4) return 0;
      return rng(c, 16, 20) || c == 24;
   endfunction

   task automatic run(input int s, input int last);
      string p;
      for (int t = 0; t <= last; t++) begin
         int c;
         c            = t + 1;
         reset        = (t == 0) || (s == 5 && t == 12);
         pulse_in     = drv_pulse(s, t);
         clr_overflow = (s == 4) && (t == 20 || t == 23);
         @(posedge clk);
         #1;
         p = $sformatf("s%0d c%0d", s, c);
         chk({p, " out_a"},  int'(out_a),  exp_out(s, c));
         chk({p, " out_b"},  int'(out_b),  exp_out(s, c));
         chk({p, " busy_a"}, int'(busy_a), exp_busy(s, c));
         chk({p, " busy_b"}, int'(busy_b), exp_busy(s, c));
         chk({p, " pend_a"}, int'(pend_a), exp_pend_a(s, c));
         chk({p, " pend_b"}, int'(pend_b), exp_pend_b(s, c));
         chk({p, " ovf_a"},  int'(ovf_a),  exp_ovf_a(s, c));
         chk({p, " ovf_b"},  int'(ovf_b),  0);
      end
   endtask

   initial begin
      reset        = 1'b1;
      pulse_in     = 1'b0;
      clr_overflow = 1'b0;
      run(1, 20);   // single pulse
      run(2, 31);   // queued pulses replayed
      run(3, 25);   // pulse on last gap cycle served directly
      run(4, 23);   // saturation, clear, and clear-vs-drop priority
      run(5, 22);   // reset mid-HIGH with pending work
      run(6, 31);   // held input counts every cycle
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
